// File: rtl/reg_serializer.sv
// Parallel-in, serial-out transmitter with Load/Ready handshake,
// Hold stall and a one-cycle Done pulse after the last bit.
module reg_serializer #(
    parameter int n         = 8,
    parameter bit LSB_FIRST = 1'b1,
    parameter int CW        = $clog2(n + 1)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [n-1:0]  Data,
    input  logic          Load,
    input  logic          Hold,
    output logic          Ready,
    output logic          SerOut,
    output logic          SerValid,
    output logic          Done,
    output logic [CW-1:0] BitsLeft
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [n-1:0]  shift, shift_n;
    logic [CW-1:0] bits, bits_n;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            shift <= '0;
            bits  <= '0;
        end else begin
            state <= state_n;
            shift <= shift_n;
            bits  <= bits_n;
        end
    end

    // Shift always moves toward the output end so the next bit lands there.
    always_comb begin
        state_n = state;
        shift_n = shift;
        bits_n  = bits;
        unique case (state)
            IDLE: begin
                if (Load) begin
                    state_n = SHIFT;
                    shift_n = Data;
                    bits_n  = CW'(n);
                end
            end
            SHIFT: begin
                if (!Hold) begin
                    if (bits == CW'(1)) begin
                        state_n = DONE;
                        shift_n = '0;
                        bits_n  = '0;
                    end else begin
                        shift_n = LSB_FIRST ? (shift >> 1) : (shift << 1);
                        bits_n  = bits - CW'(1);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                shift_n = '0;
                bits_n  = '0;
            end
        endcase
    end

    always_comb begin
        Ready    = 1'b0;
        SerValid = 1'b0;
        SerOut   = 1'b0;
        Done     = 1'b0;
        BitsLeft = bits;
        unique case (state)
            IDLE: begin
                Ready = 1'b1;
            end
            SHIFT: begin
                SerValid = 1'b1;
                SerOut   = LSB_FIRST ? shift[0] : shift[n-1];
            end
            DONE: begin
                Done = 1'b1;
            end
            default: begin
                Ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_serializer.sv
// Directed bench for reg_serializer: one LSB-first and one MSB-first
// instance share the same stimulus and are checked side by side.
`timescale 1ns/1ps
module tb_reg_serializer;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] Data;
    logic       Load;
    logic       Hold;

    logic       ready_l, ser_l, valid_l, done_l;
    logic [3:0] left_l;
    logic       ready_m, ser_m, valid_m, done_m;
    logic [3:0] left_m;

    int cnt   = 0;
    int fails = 0;

    always #10 Clock = ~Clock;

    reg_serializer #(.n(8), .LSB_FIRST(1'b1)) dut_lsb (
        .Clock(Clock), .Reset(Reset), .Data(Data), .Load(Load), .Hold(Hold),
        .Ready(ready_l), .SerOut(ser_l), .SerValid(valid_l), .Done(done_l),
        .BitsLeft(left_l)
    );

    reg_serializer #(.n(8), .LSB_FIRST(1'b0)) dut_msb (
        .Clock(Clock), .Reset(Reset), .Data(Data), .Load(Load), .Hold(Hold),
        .Ready(ready_m), .SerOut(ser_m), .SerValid(valid_m), .Done(done_m),
        .BitsLeft(left_m)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        cnt++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic rdy, input logic vld,
                             input logic dn, input int left);
        chk({tag, ".ready_l"}, 32'(ready_l), 32'(rdy));
        chk({tag, ".ready_m"}, 32'(ready_m), 32'(rdy));
        chk({tag, ".valid_l"}, 32'(valid_l), 32'(vld));
        chk({tag, ".valid_m"}, 32'(valid_m), 32'(vld));
        chk({tag, ".done_l"}, 32'(done_l), 32'(dn));
        chk({tag, ".done_m"}, 32'(done_m), 32'(dn));
        chk({tag, ".left_l"}, 32'(left_l), 32'(left));
        chk({tag, ".left_m"}, 32'(left_m), 32'(left));
    endtask

    task automatic chk_idle(input string tag);
        chk_state(tag, 1'b1, 1'b0, 1'b0, 0);
        chk({tag, ".ser_l"}, 32'(ser_l), 32'd0);
        chk({tag, ".ser_m"}, 32'(ser_m), 32'd0);
    endtask

    task automatic chk_bit(input string tag, input logic [7:0] w, input int b);
        logic [7:0] v;
        v = w;
        chk_state(tag, 1'b0, 1'b1, 1'b0, 8 - b);
        chk({tag, ".ser_l"}, 32'(ser_l), 32'(v[b]));
        chk({tag, ".ser_m"}, 32'(ser_m), 32'(v[7-b]));
    endtask

    // One full word: accept, 8 bits (optional stall), Done, back to idle.
    task automatic transfer(input string tag, input logic [7:0] w,
                            input int hold_at, input int hold_n,
                            input bit stray_loads, input bit keep_load);
        int cyc;
        Data = w;
        Load = 1'b1;
        tick();
        cyc  = 0;
        Load = keep_load;
        if (keep_load || stray_loads) Data = 8'h00;
        for (int b = 0; b < 8; b++) begin
            chk_bit($sformatf("%s.bit%0d", tag, b), w, b);
            if (hold_at != 0 && (8 - b) == hold_at) begin
                Hold = 1'b1;
                for (int h = 0; h < hold_n; h++) begin
                    tick();
                    cyc++;
                    chk_bit($sformatf("%s.hold%0d", tag, h), w, b);
                end
                Hold = 1'b0;
            end
            if (stray_loads && !keep_load) Load = (b == 2);
            tick();
            cyc++;
        end
        chk_state({tag, ".done"}, 1'b0, 1'b0, 1'b1, 0);
        chk({tag, ".done_cyc"}, 32'(cyc), 32'(8 + hold_n));
        chk({tag, ".done_ser"}, 32'(ser_l | ser_m), 32'd0);
        if (stray_loads) Load = 1'b1;
        Hold = (hold_n > 0);
        tick();
        cyc++;
        Hold = 1'b0;
        chk_idle({tag, ".idle"});
        chk({tag, ".ready_cyc"}, 32'(cyc), 32'(9 + hold_n));
        if (!keep_load) Load = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        Load  = 1'b1;
        Data  = 8'hFF;
        Hold  = 1'b0;
        tick();
        chk_idle("rst1");
        tick();
        chk_idle("rst2");
        Reset = 1'b0;
        Load  = 1'b0;
        tick();
        chk_idle("post_rst");
        tick();
        chk_idle("post_rst2");

        transfer("a5_stray", 8'hA5, 0, 0, 1'b1, 1'b0);
        transfer("c3", 8'hC3, 0, 0, 1'b0, 1'b0);
        transfer("0f_hold", 8'h0F, 5, 3, 1'b0, 1'b0);

        // Load held high: next word accepted on the first Ready edge.
        transfer("a5_b2b", 8'hA5, 0, 0, 1'b0, 1'b1);
        Data = 8'h3C;
        tick();
        chk_bit("b2b.bit0", 8'h3C, 0);
        Load = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            tick();
            chk_bit($sformatf("b2b.bit%0d", b), 8'h3C, b);
        end

        // Abort at BitsLeft=4: idle next cycle, no Done afterwards.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk_idle("abort");
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_idle($sformatf("abort_after%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 cnt, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
